// File: rtl/crypto_pkg.sv
// rtl/crypto_pkg.sv - shared owner encoding and arbiter state type for the crypto memory arbiter
package crypto_pkg;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_ENG = 1'b1;

  localparam logic [3:0] BURST_SAT = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/crypto_mem_arbiter_rr_arb2.sv
// rtl/crypto_mem_arbiter_rr_arb2.sv - combinational 2-way round-robin winner select with engine lock override
module rr_arb2
  import crypto_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       lock_hold,
  output logic       winner
);

  // req[0] is the CPU, req[1] the engine; a tie goes to whoever did not own last
  always_comb begin
    winner = OWN_CPU;
    if (lock_hold)
      winner = OWN_ENG;
    else if (req == 2'b01)
      winner = OWN_CPU;
    else if (req == 2'b10)
      winner = OWN_ENG;
    else if (req == 2'b11)
      winner = ~last_owner;
  end

endmodule

// File: rtl/crypto_mem_arbiter.sv
// rtl/crypto_mem_arbiter.sv - shares the single-port data memory between CPU load/store path and crypto engine
module crypto_mem_arbiter
  import crypto_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_LAT   = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic              eng_lock,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic [DATA_W-1:0] eng_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
    $error("crypto_mem_arbiter: MEM_LAT must be 1..4");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("crypto_mem_arbiter: MAX_BURST must be 1..15");
  end

  arb_state_t state, state_nxt;
  logic       grant_now;
  logic       capture;
  logic       winner;
  logic       lock_hold;
  logic       last_owner;
  logic [1:0] wait_cnt;
  logic [3:0] burst_cnt;

  // The engine keeps a locked burst only while it has not starved a waiting CPU
  assign lock_hold = (last_owner == OWN_ENG) & eng_req & eng_lock &
                     ((burst_cnt < 4'(MAX_BURST)) | ~cpu_req);

  rr_arb2 u_arb (
    .req       ({eng_req, cpu_req}),
    .last_owner(last_owner),
    .lock_hold (lock_hold),
    .winner    (winner)
  );

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_now = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cpu_req | eng_req) begin
          grant_now = 1'b1;
          state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: state_nxt = mem_we ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (wait_cnt == 2'd0) begin
          capture   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_gnt    <= 1'b0;
      eng_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      eng_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      eng_rdata  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      last_owner <= OWN_ENG;
      burst_cnt  <= 4'd0;
      wait_cnt   <= 2'd0;
    end else begin
      cpu_gnt    <= 1'b0;
      eng_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      eng_rvalid <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;

      if (grant_now) begin
        mem_en     <= 1'b1;
        last_owner <= winner;
        if (winner == OWN_ENG) begin
          eng_gnt   <= 1'b1;
          mem_we    <= eng_we;
          mem_addr  <= eng_addr;
          mem_wdata <= eng_wdata;
          if (eng_lock)
            burst_cnt <= (burst_cnt == BURST_SAT) ? BURST_SAT : burst_cnt + 4'd1;
          else
            burst_cnt <= 4'd0;
        end else begin
          cpu_gnt   <= 1'b1;
          mem_we    <= cpu_we;
          mem_addr  <= cpu_addr;
          mem_wdata <= cpu_wdata;
          burst_cnt <= 4'd0;
        end
      end

      if (state == S_ACCESS && !mem_we)
        wait_cnt <= 2'(MEM_LAT - 1);
      else if (state == S_WAIT && wait_cnt != 2'd0)
        wait_cnt <= wait_cnt - 2'd1;

      if (capture) begin
        if (last_owner == OWN_ENG) begin
          eng_rdata  <= mem_rdata;
          eng_rvalid <= 1'b1;
        end else begin
          cpu_rdata  <= mem_rdata;
          cpu_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_crypto_mem_arbiter.sv
// tb/tb_crypto_mem_arbiter.sv - scoreboard bench for crypto_mem_arbiter (MEM_LAT 1 and 3 instances)
module tb_crypto_mem_arbiter;

  typedef struct packed {
    logic       own;
    logic       we;
    logic       lock;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = 8'h0, cpu_wdata = 8'h0;
  logic       eng_req = 1'b0, eng_we = 1'b0, eng_lock = 1'b0;
  logic [7:0] eng_addr = 8'h0, eng_wdata = 8'h0;

  logic       cpu_gnt, cpu_rvalid, cpu_stall, eng_gnt, eng_rvalid, mem_en, mem_we, busy;
  logic [7:0] cpu_rdata, eng_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       l3_cpu_gnt, l3_cpu_rvalid, l3_cpu_stall, l3_eng_gnt, l3_eng_rvalid;
  logic       l3_mem_en, l3_mem_we, l3_busy;
  logic [7:0] l3_cpu_rdata, l3_eng_rdata, l3_mem_addr, l3_mem_wdata, l3_mem_rdata;

  crypto_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1), .MAX_BURST(4)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .eng_req(eng_req), .eng_we(eng_we), .eng_lock(eng_lock), .eng_addr(eng_addr),
    .eng_wdata(eng_wdata), .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  crypto_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3), .MAX_BURST(4)) u_dut_lat3 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(l3_cpu_gnt), .cpu_rvalid(l3_cpu_rvalid), .cpu_rdata(l3_cpu_rdata),
    .cpu_stall(l3_cpu_stall),
    .eng_req(eng_req), .eng_we(eng_we), .eng_lock(eng_lock), .eng_addr(eng_addr),
    .eng_wdata(eng_wdata), .eng_gnt(l3_eng_gnt), .eng_rvalid(l3_eng_rvalid),
    .eng_rdata(l3_eng_rdata),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
    .mem_rdata(l3_mem_rdata), .busy(l3_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_mem(input logic [7:0] a);
    if (a == 8'h10) return 8'hA5;
    if (a == 8'h40) return 8'h5E;
    return a ^ 8'h5A;
  endfunction

  // Memory models: data appears MEM_LAT cycles after the address is presented
  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] rp1;
  logic [7:0] rp3 [3];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem1[i] <= exp_mem(8'(i));
    end else if (mem_en && mem_we) begin
      mem1[mem_addr] <= mem_wdata;
    end
    rp1 <= mem1[mem_addr];
  end
  assign mem_rdata = rp1;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem3[i] <= exp_mem(8'(i));
    end else if (l3_mem_en && l3_mem_we) begin
      mem3[l3_mem_addr] <= l3_mem_wdata;
    end
    rp3[0] <= mem3[l3_mem_addr];
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign l3_mem_rdata = rp3[2];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_gnt = -1;
  bit   mon_on = 1'b0;
  bit   spacing_on = 1'b0;
  acc_t cpu_q[$], eng_q[$], exp_q[$];
  logic [7:0] exp_crd[$], exp_erd[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic acc_t mk(input logic own, input logic we, input logic lock,
                              input logic [7:0] addr, input logic [7:0] wdata);
    acc_t a;
    a.own = own; a.we = we; a.lock = lock; a.addr = addr; a.wdata = wdata;
    return a;
  endfunction

  task automatic add_req(input acc_t a);
    if (a.own) eng_q.push_back(a);
    else cpu_q.push_back(a);
  endtask

  task automatic expect_grant(input acc_t a);
    exp_q.push_back(a);
    if (!a.we) begin
      if (a.own) exp_erd.push_back(exp_mem(a.addr));
      else exp_crd.push_back(exp_mem(a.addr));
    end
  endtask

  task automatic present();
    cpu_req = (cpu_q.size() != 0);
    if (cpu_req) begin
      cpu_we = cpu_q[0].we; cpu_addr = cpu_q[0].addr; cpu_wdata = cpu_q[0].wdata;
    end
    eng_req = (eng_q.size() != 0);
    eng_lock = 1'b0;
    if (eng_req) begin
      eng_we = eng_q[0].we; eng_addr = eng_q[0].addr; eng_wdata = eng_q[0].wdata;
      eng_lock = eng_q[0].lock;
    end
  endtask

  task automatic monitor();
    acc_t e;
    logic [7:0] d;
    if (cpu_gnt || eng_gnt) begin
      check("gnt_excl", cpu_gnt & eng_gnt, 0);
      check("gnt_mem_en", mem_en, 1);
      if (exp_q.size() == 0) begin
        check("unexp_gnt", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("gnt_owner", eng_gnt, e.own);
        check("acc_we", mem_we, e.we);
        check("acc_addr", mem_addr, e.addr);
        if (e.we) check("acc_wdata", mem_wdata, e.wdata);
      end
      if (spacing_on && last_gnt >= 0) check("gnt_spacing", cyc - last_gnt, 2);
      last_gnt = cyc;
    end else begin
      check("en_no_gnt", mem_en, 0);
    end
    if (cpu_rvalid || eng_rvalid) check("rv_excl", cpu_rvalid & eng_rvalid, 0);
    if (cpu_rvalid) begin
      if (exp_crd.size() == 0) check("unexp_cpu_rv", 1, 0);
      else begin d = exp_crd.pop_front(); check("cpu_rdata", cpu_rdata, d); end
    end
    if (eng_rvalid) begin
      if (exp_erd.size() == 0) check("unexp_eng_rv", 1, 0);
      else begin d = exp_erd.pop_front(); check("eng_rdata", eng_rdata, d); end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (mon_on) begin
      monitor();
      if (cpu_gnt && cpu_q.size() != 0) cpu_q.delete(0);
      if (eng_gnt && eng_q.size() != 0) eng_q.delete(0);
      present();
    end
  endtask

  task automatic run(input string tag, input int bound);
    int n;
    n = 0;
    mon_on = 1'b1;
    present();
    while ((exp_q.size() + exp_crd.size() + exp_erd.size()) != 0 && n < bound) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, exp_q.size() + exp_crd.size() + exp_erd.size(), 0);
    check({tag, "_leftover"}, cpu_q.size() + eng_q.size(), 0);
    repeat (3) step();
    mon_on = 1'b0;
    spacing_on = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cpu_req = 1'b0; eng_req = 1'b0; eng_lock = 1'b0;
    cpu_q.delete(); eng_q.delete(); exp_q.delete(); exp_crd.delete(); exp_erd.delete();
    last_gnt = -1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ctl", {cpu_gnt, eng_gnt, cpu_rvalid, eng_rvalid, mem_en, mem_we, busy, cpu_stall}, 0);
    check("rst_data", {cpu_rdata, eng_rdata, mem_addr, mem_wdata}, 0);
    reset = 1'b0;

    // CPU read of 0x10 with MEM_LAT=1: gnt at 1, rvalid at 3
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    #1;
    check("t1_stall_c0", cpu_stall, 1);
    step();
    check("t1_gnt", cpu_gnt, 1);
    check("t1_en", {mem_en, mem_we}, 2'b10);
    check("t1_addr", mem_addr, 8'h10);
    check("t1_stall_c1", cpu_stall, 0);
    check("t1_busy_c1", busy, 1);
    cpu_req = 1'b0;
    step();
    check("t1_c2", {cpu_gnt, mem_en, cpu_rvalid, busy, cpu_stall}, 5'b00010);
    step();
    check("t1_rvalid", {cpu_rvalid, eng_rvalid, busy, cpu_stall}, 4'b1000);
    check("t1_rdata", cpu_rdata, 8'hA5);
    step();
    check("t1_rv_pulse", cpu_rvalid, 0);

    // Engine write 0x3C to 0x20
    eng_req = 1'b1; eng_we = 1'b1; eng_addr = 8'h20; eng_wdata = 8'h3C;
    step();
    check("t2_gnt", {eng_gnt, cpu_gnt}, 2'b10);
    check("t2_en", {mem_en, mem_we, busy}, 3'b111);
    check("t2_addr", mem_addr, 8'h20);
    check("t2_wdata", mem_wdata, 8'h3C);
    eng_req = 1'b0;
    step();
    check("t2_after", {mem_en, mem_we, busy, eng_rvalid}, 0);
    check("t2_addr_hold", mem_addr, 8'h20);
    step();
    check("t2_no_rv", {eng_rvalid, cpu_rvalid, mem_en}, 0);

    // Continuous writes without lock alternate, CPU first
    do_reset();
    for (int i = 0; i < 3; i++) begin
      add_req(mk(1'b0, 1'b1, 1'b0, 8'h80 + 8'(i), 8'hC0 + 8'(i)));
      add_req(mk(1'b1, 1'b1, 1'b0, 8'h90 + 8'(i), 8'hE0 + 8'(i)));
      expect_grant(mk(1'b0, 1'b1, 1'b0, 8'h80 + 8'(i), 8'hC0 + 8'(i)));
      expect_grant(mk(1'b1, 1'b1, 1'b0, 8'h90 + 8'(i), 8'hE0 + 8'(i)));
    end
    spacing_on = 1'b1;
    run("t3", 60);

    // Locked engine burst against a waiting CPU: 4 ENG, CPU, then the burst restarts
    do_reset();
    for (int i = 0; i < 7; i++) add_req(mk(1'b1, 1'b1, 1'b1, 8'hB0 + 8'(i), 8'h70 + 8'(i)));
    for (int i = 0; i < 2; i++) add_req(mk(1'b0, 1'b1, 1'b0, 8'hA0 + 8'(i), 8'h60 + 8'(i)));
    for (int i = 0; i < 4; i++) expect_grant(mk(1'b1, 1'b1, 1'b1, 8'hB0 + 8'(i), 8'h70 + 8'(i)));
    expect_grant(mk(1'b0, 1'b1, 1'b0, 8'hA0, 8'h60));
    for (int i = 4; i < 7; i++) expect_grant(mk(1'b1, 1'b1, 1'b1, 8'hB0 + 8'(i), 8'h70 + 8'(i)));
    expect_grant(mk(1'b0, 1'b1, 1'b0, 8'hA1, 8'h61));
    spacing_on = 1'b1;
    run("t4", 80);

    // Mixed reads: data routed to the owning requester only
    do_reset();
    add_req(mk(1'b0, 1'b0, 1'b0, 8'h11, 8'h00));
    add_req(mk(1'b0, 1'b0, 1'b0, 8'h12, 8'h00));
    add_req(mk(1'b1, 1'b0, 1'b0, 8'h13, 8'h00));
    expect_grant(mk(1'b0, 1'b0, 1'b0, 8'h11, 8'h00));
    expect_grant(mk(1'b1, 1'b0, 1'b0, 8'h13, 8'h00));
    expect_grant(mk(1'b0, 1'b0, 1'b0, 8'h12, 8'h00));
    run("t6", 60);

    // MEM_LAT=3 engine read: rvalid at T+4, competing CPU write waits until capture
    do_reset();
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = 8'h40;
    step();
    check("t5_gnt", {l3_eng_gnt, l3_mem_en, l3_mem_we}, 3'b110);
    check("t5_addr", l3_mem_addr, 8'h40);
    eng_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h22; cpu_wdata = 8'h11;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("t5_wait_quiet", {l3_mem_en, l3_eng_rvalid, l3_cpu_gnt}, 0);
      check("t5_wait_stall", {l3_cpu_stall, l3_busy}, 2'b11);
    end
    step();
    check("t5_rvalid", {l3_eng_rvalid, l3_cpu_rvalid, l3_mem_en}, 3'b100);
    check("t5_rdata", l3_eng_rdata, 8'h5E);
    step();
    check("t5_next_gnt", {l3_cpu_gnt, l3_mem_en, l3_mem_we}, 3'b111);
    check("t5_next_addr", l3_mem_addr, 8'h22);
    cpu_req = 1'b0;
    repeat (2) step();

    // Reset during S_WAIT abandons the read
    do_reset();
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = 8'h40;
    step();
    check("t7_gnt", l3_eng_gnt, 1);
    eng_req = 1'b0;
    repeat (2) step();
    check("t7_in_wait", {l3_busy, l3_mem_en, l3_eng_rvalid}, 3'b100);
    reset = 1'b1;
    #1;
    check("t7_rst_ctl", {l3_cpu_gnt, l3_eng_gnt, l3_cpu_rvalid, l3_eng_rvalid,
                         l3_mem_en, l3_mem_we, l3_busy}, 0);
    check("t7_rst_data", {l3_mem_addr, l3_mem_wdata, l3_cpu_rdata, l3_eng_rdata}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t7_no_rv", {l3_eng_rvalid, l3_cpu_rvalid, l3_mem_en}, 0);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    step();
    check("t7_fresh_gnt", {l3_cpu_gnt, l3_mem_en}, 2'b11);
    cpu_req = 1'b0;
    repeat (3) step();
    step();
    check("t7_fresh_rv", {l3_cpu_rvalid, l3_eng_rvalid}, 2'b10);
    check("t7_fresh_rdata", l3_cpu_rdata, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
